// File: rtl/mag_estimator.sv
// Alpha-max/beta-min magnitude estimator with a 3-stage pipeline and a
// non-overlapping window producing mean and peak of every 2^LOG_WIN magnitudes.
module mag_estimator #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG_WIN    = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] i,
  input  logic signed [DATA_WIDTH-1:0] q,
  input  logic                         input_strobe,
  input  logic [1:0]                   mode,
  output logic [DATA_WIDTH-1:0]        mag,
  output logic                         mag_stb,
  output logic [DATA_WIDTH-1:0]        avg_mag,
  output logic [DATA_WIDTH-1:0]        peak_mag,
  output logic                         avg_stb
);

  localparam int AW = DATA_WIDTH + LOG_WIN;

  // Two's-complement negate; the most negative input maps to 2^(DATA_WIDTH-1).
  function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? (~x + DATA_WIDTH'(1'b1)) : x;
  endfunction

  logic [DATA_WIDTH-1:0] abs_i_r, abs_q_r, max_r, min_r, mag_r;
  logic [1:0]            mode1_r, mode2_r;
  logic                  v1_r, v2_r, mag_stb_r;
  logic [LOG_WIN-1:0]    cnt_r;
  logic [AW-1:0]         acc_r;
  logic [DATA_WIDTH-1:0] peak_r, avg_r, peak_out_r;
  logic                  avg_stb_r;

  logic [DATA_WIDTH-1:0] mag_next_s, peak_next_s, avg_next_s;
  logic [AW-1:0]         acc_sum_s;

  // Shift-and-add combination of max/min for the sample's own mode.
  always_comb begin
    mag_next_s = max_r;
    case (mode2_r)
      2'd0:    mag_next_s = max_r + (min_r >> 2);
      2'd1:    mag_next_s = max_r + (min_r >> 1);
      2'd2:    mag_next_s = max_r + (min_r >> 2) + (min_r >> 3);
      2'd3:    mag_next_s = max_r - (max_r >> 4) + (min_r >> 1) - (min_r >> 5);
      default: mag_next_s = max_r;
    endcase
  end

  // Window arithmetic on the magnitude currently being presented.
  always_comb begin
    acc_sum_s  = acc_r + {{LOG_WIN{1'b0}}, mag_r};
    avg_next_s = acc_sum_s[AW-1:LOG_WIN];
    if (mag_r > peak_r) begin
      peak_next_s = mag_r;
    end else begin
      peak_next_s = peak_r;
    end
  end

  // Pipeline: abs -> max/min -> magnitude; valid bits carry each sample's slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      abs_i_r   <= '0;
      abs_q_r   <= '0;
      mode1_r   <= 2'd0;
      v1_r      <= 1'b0;
      max_r     <= '0;
      min_r     <= '0;
      mode2_r   <= 2'd0;
      v2_r      <= 1'b0;
      mag_r     <= '0;
      mag_stb_r <= 1'b0;
    end else if (enable) begin
      v1_r <= input_strobe;
      if (input_strobe) begin
        abs_i_r <= abs_val(i);
        abs_q_r <= abs_val(q);
        mode1_r <= mode;
      end
      v2_r <= v1_r;
      if (v1_r) begin
        mode2_r <= mode1_r;
        if (abs_i_r >= abs_q_r) begin
          max_r <= abs_i_r;
          min_r <= abs_q_r;
        end else begin
          max_r <= abs_q_r;
          min_r <= abs_i_r;
        end
      end
      mag_stb_r <= v2_r;
      if (v2_r) begin
        mag_r <= mag_next_s;
      end
    end
  end

  // Window accumulation; the closing sample is folded in and state clears together.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r      <= '0;
      acc_r      <= '0;
      peak_r     <= '0;
      avg_r      <= '0;
      peak_out_r <= '0;
      avg_stb_r  <= 1'b0;
    end else if (enable) begin
      avg_stb_r <= 1'b0;
      if (mag_stb_r) begin
        if (&cnt_r) begin
          avg_r      <= avg_next_s;
          peak_out_r <= peak_next_s;
          avg_stb_r  <= 1'b1;
          cnt_r      <= '0;
          acc_r      <= '0;
          peak_r     <= '0;
        end else begin
          cnt_r  <= cnt_r + LOG_WIN'(1'b1);
          acc_r  <= acc_sum_s;
          peak_r <= peak_next_s;
        end
      end
    end
  end

  // Strobes are held while frozen and shown only in enabled cycles.
  assign mag      = mag_r;
  assign mag_stb  = mag_stb_r & enable;
  assign avg_mag  = avg_r;
  assign peak_mag = peak_out_r;
  assign avg_stb  = avg_stb_r & enable;

endmodule

// File: tb/tb_mag_estimator.sv
// Directed bench for mag_estimator (DATA_WIDTH=16, LOG_WIN=2).
module tb_mag_estimator;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic signed [15:0] i, q;
  logic               input_strobe;
  logic [1:0]         mode;
  logic [15:0]        mag, avg_mag, peak_mag;
  logic               mag_stb, avg_stb;

  int checks   = 0;
  int failures = 0;

  int          cyc     = 0;
  int          bad_cnt = 0;
  int          avg_cnt = 0;
  int          avg_cyc = 0;
  logic [15:0] last_avg  = 16'd0;
  logic [15:0] last_peak = 16'd0;
  logic [15:0] mag_q[$];
  int          stb_cyc[$];
  int          in_cyc[$];

  always #5 clock = ~clock;

  mag_estimator #(.DATA_WIDTH(16), .LOG_WIN(2)) dut (
    .clock(clock), .reset(reset), .enable(enable), .i(i), .q(q),
    .input_strobe(input_strobe), .mode(mode), .mag(mag), .mag_stb(mag_stb),
    .avg_mag(avg_mag), .peak_mag(peak_mag), .avg_stb(avg_stb)
  );

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (input_strobe && enable && !reset) in_cyc.push_back(cyc);
    if (mag_stb) begin
      mag_q.push_back(mag);
      stb_cyc.push_back(cyc);
    end
    if (avg_stb) begin
      avg_cnt   <= avg_cnt + 1;
      avg_cyc   <= cyc;
      last_avg  <= avg_mag;
      last_peak <= peak_mag;
    end
    if (!enable && (mag_stb || avg_stb)) bad_cnt <= bad_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic signed [15:0] ii,
                       input logic signed [15:0] qq, input logic [1:0] m);
    @(posedge clock); #1;
    input_strobe = s; i = ii; q = qq; mode = m;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 16'sd0, 16'sd0, 2'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset = 1'b1; input_strobe = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  int b, ib, a0;
  logic [15:0] exp_alt [8];
  logic [1:0]  mode_alt [8];

  initial begin
    reset = 1'b1; enable = 1'b1; input_strobe = 1'b0;
    i = 16'sd0; q = 16'sd0; mode = 2'd0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_mag", mag, 16'd0);
    check("rst_mag_stb", mag_stb, 1'b0);
    check("rst_avg", avg_mag, 16'd0);
    check("rst_peak", peak_mag, 16'd0);
    check("rst_avg_stb", avg_stb, 1'b0);
    reset = 1'b0;

    // Four modes back to back on one sample
    b = mag_q.size(); ib = in_cyc.size(); a0 = avg_cnt;
    for (int m = 0; m < 4; m++) drive(1'b1, 16'sd3000, -16'sd4000, 2'(m));
    idle(8);
    check("t1_count", mag_q.size() - b, 4);
    check("t1_m0", mag_q[b], 16'd4750);
    check("t1_m1", mag_q[b+1], 16'd5500);
    check("t1_m2", mag_q[b+2], 16'd5125);
    check("t1_m3", mag_q[b+3], 16'd5157);
    check("t1_latency", stb_cyc[b] - in_cyc[ib], 3);
    check("t1_consecutive", stb_cyc[b+3] - stb_cyc[b], 3);
    check("t1_avg_cnt", avg_cnt - a0, 1);
    check("t1_avg", last_avg, 16'd5133);
    check("t1_peak", last_peak, 16'd5500);

    // Most negative inputs
    b = mag_q.size();
    drive(1'b1, -16'sd32768, -16'sd32768, 2'd1);
    drive(1'b1, -16'sd32768, 16'sd0, 2'd0);
    idle(6);
    check("t2_count", mag_q.size() - b, 2);
    check("t2_tie_neg", mag_q[b], 16'd49152);
    check("t2_neg_zero", mag_q[b+1], 16'd32768);

    // Window mean and peak, then the next window
    pulse_reset();
    b = mag_q.size(); a0 = avg_cnt;
    drive(1'b1, 16'sd100, 16'sd0, 2'd0);
    drive(1'b1, -16'sd200, 16'sd0, 2'd0);
    drive(1'b1, 16'sd300, 16'sd0, 2'd0);
    drive(1'b1, 16'sd0, 16'sd401, 2'd0);
    idle(7);
    check("t3_count", mag_q.size() - b, 4);
    check("t3_mag401", mag_q[b+3], 16'd401);
    check("t3_avg_cnt", avg_cnt - a0, 1);
    check("t3_avg_timing", avg_cyc - stb_cyc[b+3], 1);
    check("t3_avg", last_avg, 16'd250);
    check("t3_peak", last_peak, 16'd401);
    drive(1'b1, 16'sd50, 16'sd0, 2'd0);
    idle(6);
    check("t3_hold_avg", avg_mag, 16'd250);
    check("t3_hold_peak", peak_mag, 16'd401);
    check("t3_no_early_avg", avg_cnt - a0, 1);
    drive(1'b1, 16'sd60, 16'sd0, 2'd0);
    drive(1'b1, 16'sd80, 16'sd0, 2'd0);
    drive(1'b1, 16'sd70, 16'sd0, 2'd0);
    idle(7);
    check("t3_avg2_cnt", avg_cnt - a0, 2);
    check("t3_avg2", last_avg, 16'd65);
    check("t3_peak2", last_peak, 16'd80);

    // Enable low for 5 cycles while samples are in flight
    b = mag_q.size(); a0 = avg_cnt;
    for (int k = 0; k < 12; k++) begin
      if (k == 5) begin
        for (int w = 0; w < 5; w++) begin
          @(posedge clock); #1;
          enable = 1'b0; input_strobe = 1'b0;
        end
        enable = 1'b1;
      end
      drive(1'b1, 16'(1000 + 10 * k), 16'sd0, 2'd0);
    end
    idle(8);
    check("t4_count", mag_q.size() - b, 12);
    for (int k = 0; k < 12; k++) check($sformatf("t4_val%0d", k), mag_q[b+k], 32'(1000 + 10 * k));
    check("t4_no_stb_disabled", bad_cnt, 0);
    check("t4_avg_cnt", avg_cnt - a0, 3);
    check("t4_avg", last_avg, 16'd1095);
    check("t4_peak", last_peak, 16'd1110);

    // Reset mid-window with samples in flight
    drive(1'b1, 16'sd500, 16'sd0, 2'd0);
    drive(1'b1, 16'sd500, 16'sd0, 2'd0);
    idle(6);
    drive(1'b1, 16'sd700, 16'sd0, 2'd0);
    drive(1'b1, 16'sd700, 16'sd0, 2'd0);
    @(posedge clock); #1;
    reset = 1'b1; input_strobe = 1'b0;
    b = mag_q.size(); a0 = avg_cnt;
    @(posedge clock); #1;
    check("t5_rst_avg", avg_mag, 16'd0);
    check("t5_rst_peak", peak_mag, 16'd0);
    reset = 1'b0;
    idle(5);
    check("t5_no_stale", mag_q.size() - b, 0);
    for (int k = 0; k < 4; k++) drive(1'b1, 16'sd1000, 16'sd0, 2'd0);
    idle(8);
    check("t5_count", mag_q.size() - b, 4);
    check("t5_avg_cnt", avg_cnt - a0, 1);
    check("t5_avg", last_avg, 16'd1000);
    check("t5_peak", last_peak, 16'd1000);

    // Mode changes every cycle
    mode_alt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd3, 2'd2};
    exp_alt  = '{16'd4750, 16'd5500, 16'd5125, 16'd5157,
                 16'd5500, 16'd4750, 16'd5157, 16'd5125};
    b = mag_q.size();
    for (int k = 0; k < 8; k++) drive(1'b1, 16'sd3000, -16'sd4000, mode_alt[k]);
    idle(8);
    check("t6_count", mag_q.size() - b, 8);
    for (int k = 0; k < 8; k++) check($sformatf("t6_val%0d", k), mag_q[b+k], 32'(exp_alt[k]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
